// File: rtl/mem_responder_l7_if.sv
// Request/response bus between a memory client (master) and the
// memory responder (slave). op: 0 = read, 1 = write.
interface mem_responder_l7_if #(
    parameter int p_opaq_bits = 8
);
    logic                   req_val;
    logic                   req_rdy;
    logic                   req_op;
    logic [p_opaq_bits-1:0] req_opaque;
    logic [31:0]            req_addr;
    logic [3:0]             req_strb;
    logic [31:0]            req_data;

    logic                   resp_val;
    logic                   resp_rdy;
    logic                   resp_op;
    logic [p_opaq_bits-1:0] resp_opaque;
    logic [31:0]            resp_addr;
    logic [3:0]             resp_strb;
    logic [31:0]            resp_data;

    modport master (
        output req_val, req_op, req_opaque, req_addr, req_strb, req_data,
        input  req_rdy,
        input  resp_val, resp_op, resp_opaque, resp_addr, resp_strb, resp_data,
        output resp_rdy
    );

    modport slave (
        input  req_val, req_op, req_opaque, req_addr, req_strb, req_data,
        output req_rdy,
        output resp_val, resp_op, resp_opaque, resp_addr, resp_strb, resp_data,
        input  resp_rdy
    );
endinterface

// File: rtl/mem_responder_l7.sv
// Memory-side responder: word-addressed store with byte-strobe writes,
// in-order responses after a fixed latency through a circular queue.
module mem_responder_l7 #(
    parameter int p_opaq_bits   = 8,
    parameter int p_num_words   = 256,
    parameter int p_latency     = 1,
    parameter int p_queue_depth = 4
) (
    input  logic               clk,
    input  logic               rst,
    mem_responder_l7_if.slave  mem
);
    localparam logic mem_msg_read  = 1'b0;
    localparam logic mem_msg_write = 1'b1;

    localparam int idx_w = $clog2(p_num_words);
    localparam int ptr_w = (p_queue_depth > 1) ? $clog2(p_queue_depth) : 1;
    localparam int cnt_w = $clog2(p_queue_depth + 1);
    // countdown only ever holds values 0 .. p_latency-1
    localparam int cd_w  = (p_latency > 1) ? $clog2(p_latency) : 1;

    localparam logic [cd_w-1:0]  cd_init  = cd_w'(p_latency - 1);
    localparam logic [cnt_w-1:0] depth_c  = cnt_w'(p_queue_depth);
    localparam logic [ptr_w-1:0] last_ptr = ptr_w'(p_queue_depth - 1);

    logic [31:0]            store    [p_num_words];

    logic                   q_op     [p_queue_depth];
    logic [p_opaq_bits-1:0] q_opaque [p_queue_depth];
    logic [31:0]            q_addr   [p_queue_depth];
    logic [3:0]             q_strb   [p_queue_depth];
    logic [31:0]            q_data   [p_queue_depth];
    logic [cd_w-1:0]        q_cd     [p_queue_depth];

    logic [ptr_w-1:0]       head;
    logic [ptr_w-1:0]       tail;
    logic [cnt_w-1:0]       count;

    logic                   accept;
    logic                   dequeue;
    logic [idx_w-1:0]       idx;

    // Low two address bits and bits above the store size are ignored (aliasing).
    assign idx     = mem.req_addr[idx_w+1:2];

    // Ready/valid come only from registered state; no bypass when full.
    assign mem.req_rdy  = (count < depth_c);
    assign accept       = mem.req_val & mem.req_rdy;
    assign mem.resp_val = (count != '0) && (q_cd[head] == '0);
    assign dequeue      = mem.resp_val & mem.resp_rdy;

    assign mem.resp_op     = q_op[head];
    assign mem.resp_opaque = q_opaque[head];
    assign mem.resp_addr   = q_addr[head];
    assign mem.resp_strb   = q_strb[head];
    assign mem.resp_data   = q_data[head];

    // Byte-strobed write into the backing store; contents are never reset.
    always_ff @(posedge clk) begin
        if (accept && mem.req_op == mem_msg_write) begin
            for (int b = 0; b < 4; b++) begin
                if (mem.req_strb[b]) begin
                    store[idx][8*b +: 8] <= mem.req_data[8*b +: 8];
                end
            end
        end
    end

    // Queue payload and countdowns; stale entries are harmless because count gates validity.
    always_ff @(posedge clk) begin
        for (int i = 0; i < p_queue_depth; i++) begin
            if (q_cd[i] != '0) begin
                q_cd[i] <= q_cd[i] - 1'b1;
            end
        end
        if (accept) begin
            q_op[tail]     <= mem.req_op;
            q_opaque[tail] <= mem.req_opaque;
            q_addr[tail]   <= mem.req_addr;
            q_strb[tail]   <= mem.req_strb;
            q_data[tail]   <= (mem.req_op == mem_msg_read) ? store[idx] : 32'h0;
            q_cd[tail]     <= cd_init;
        end
    end

    // Head/tail pointers and occupancy; reset discards everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            head  <= '0;
            tail  <= '0;
            count <= '0;
        end else begin
            if (accept) begin
                tail <= (tail == last_ptr) ? '0 : tail + 1'b1;
            end
            if (dequeue) begin
                head <= (head == last_ptr) ? '0 : head + 1'b1;
            end
            case ({accept, dequeue})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: tb/tb_mem_responder_l7.sv
// Scoreboard bench: the driver pushes expected responses computed from a
// plain array memory model; a negedge monitor compares and pops.
module tb_mem_responder_l7;
    localparam int lat    = 3;
    localparam int depth  = 4;
    localparam int nwords = 256;
    localparam logic op_rd = 1'b0;
    localparam logic op_wr = 1'b1;

    typedef struct {
        logic        op;
        logic [7:0]  opq;
        logic [31:0] addr;
        logic [3:0]  strb;
        logic [31:0] data;
        int          ready;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    mem_responder_l7_if #(.p_opaq_bits(8)) bus();

    mem_responder_l7 #(
        .p_opaq_bits  (8),
        .p_num_words  (nwords),
        .p_latency    (lat),
        .p_queue_depth(depth)
    ) dut (
        .clk(clk),
        .rst(rst),
        .mem(bus)
    );

    exp_t        sb[$];
    logic [31:0] model_mem [nwords];
    int          checks = 0;
    int          errors = 0;
    int          mcyc   = 0;
    bit          rdy_rand  = 1'b0;
    logic        rdy_fixed = 1'b1;

    // resp_rdy driver
    initial begin
        bus.resp_rdy = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            bus.resp_rdy = rdy_rand ? 1'($urandom_range(0, 1)) : rdy_fixed;
        end
    end

    // monitor: compares DUT outputs against the scoreboard head
    initial begin
        bit   exp_v;
        exp_t h;
        forever begin
            @(negedge clk);
            mcyc++;
            if (rst === 1'b0) begin
                exp_v = 1'b0;
                if (sb.size() > 0) exp_v = (mcyc >= sb[0].ready);
                checks++;
                if (bus.req_rdy !== (sb.size() < depth)) begin
                    errors++;
                    $display("FAIL req_rdy cyc=%0d got=%b want=%b", mcyc, bus.req_rdy, (sb.size() < depth));
                end
                checks++;
                if (bus.resp_val !== exp_v) begin
                    errors++;
                    $display("FAIL resp_val cyc=%0d got=%b want=%b", mcyc, bus.resp_val, exp_v);
                end
                if (bus.resp_val === 1'b1 && exp_v) begin
                    h = sb[0];
                    checks++;
                    if (bus.resp_op !== h.op || bus.resp_opaque !== h.opq || bus.resp_addr !== h.addr ||
                        bus.resp_strb !== h.strb || bus.resp_data !== h.data) begin
                        errors++;
                        $display("FAIL resp_msg cyc=%0d got=%b:%h:%h:%b:%h want=%b:%h:%h:%b:%h", mcyc,
                                 bus.resp_op, bus.resp_opaque, bus.resp_addr, bus.resp_strb, bus.resp_data,
                                 h.op, h.opq, h.addr, h.strb, h.data);
                    end
                    if (bus.resp_rdy === 1'b1) void'(sb.pop_front());
                end
            end
        end
    end

    task automatic send(input logic op, input logic [31:0] addr, input logic [3:0] strb,
                        input logic [31:0] data, input logic [7:0] opq);
        int   wait_n = 0;
        int   idx;
        exp_t e;
        bus.req_val    = 1'b1;
        bus.req_op     = op;
        bus.req_addr   = addr;
        bus.req_strb   = strb;
        bus.req_data   = data;
        bus.req_opaque = opq;
        @(negedge clk);
        while (bus.req_rdy !== 1'b1 && wait_n < 100) begin
            wait_n++;
            @(negedge clk);
        end
        if (bus.req_rdy !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL send_timeout got=req_rdy_low want=accept addr=%h", addr);
            bus.req_val = 1'b0;
            return;
        end
        @(posedge clk);
        idx     = int'((addr >> 2) % nwords);
        e.op    = op;
        e.opq   = opq;
        e.addr  = addr;
        e.strb  = strb;
        e.ready = mcyc + lat;
        if (op == op_wr) begin
            for (int b = 0; b < 4; b++)
                if (strb[b]) model_mem[idx][8*b +: 8] = data[8*b +: 8];
            e.data = 32'h0;
        end else begin
            e.data = model_mem[idx];
        end
        sb.push_back(e);
        #1;
        bus.req_val = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        int w;
        bus.req_val    = 1'b0;
        bus.req_op     = op_rd;
        bus.req_addr   = '0;
        bus.req_strb   = '0;
        bus.req_data   = '0;
        bus.req_opaque = '0;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0;
        idle(2);

        // fill the whole store so every later read has a known value
        for (int i = 0; i < nwords; i++)
            send(op_wr, 32'(i * 4), 4'hF, $urandom, 8'(i));

        // basic write/read, strobed write, empty strobe
        send(op_wr, 32'h10, 4'hF, 32'hDEADBEEF, 8'h03);
        send(op_rd, 32'h10, 4'hF, 32'h0, 8'h04);
        send(op_wr, 32'h10, 4'b0010, 32'h0000AB00, 8'h05);
        send(op_rd, 32'h10, 4'b0000, 32'h0, 8'h06);
        send(op_wr, 32'h10, 4'b0000, 32'hFFFFFFFF, 8'h07);
        send(op_rd, 32'h10, 4'hF, 32'h0, 8'h08);

        // pipelined stream
        for (int i = 0; i < 8; i++) send(op_wr, 32'(i * 4), 4'hF, 32'(i + 1), 8'(i));
        for (int i = 0; i < 8; i++) send(op_rd, 32'(i * 4), 4'hF, 32'h0, 8'(8'h20 + i));

        // backpressure: fill queue, single-cycle release, then drain
        idle(8);
        rdy_fixed = 1'b0;
        idle(1);
        for (int i = 0; i < 4; i++) send(op_rd, 32'(i * 4), 4'hF, 32'h0, 8'(8'h40 + i));
        idle(6);
        rdy_fixed = 1'b1;
        idle(1);
        rdy_fixed = 1'b0;
        idle(4);
        rdy_fixed = 1'b1;
        idle(6);

        // aliasing
        send(op_wr, 32'h400, 4'hF, 32'h12345678, 8'h50);
        send(op_rd, 32'h000, 4'hF, 32'h0, 8'h51);

        // randomized traffic with random backpressure
        rdy_rand = 1'b1;
        for (int i = 0; i < 300; i++) begin
            if ($urandom_range(0, 3) == 0) idle(1);
            send(1'($urandom_range(0, 1)), $urandom, 4'($urandom), $urandom, 8'($urandom));
        end
        rdy_rand  = 1'b0;
        rdy_fixed = 1'b1;
        idle(12);

        // reset with requests outstanding
        rdy_fixed = 1'b0;
        idle(1);
        send(op_wr, 32'h80, 4'hF, 32'hCAFEF00D, 8'h60);
        send(op_rd, 32'h84, 4'hF, 32'h0, 8'h61);
        rst = 1'b1;
        @(posedge clk);
        sb.delete();
        #1;
        rst = 1'b0;
        rdy_fixed = 1'b1;
        idle(5);
        send(op_rd, 32'h80, 4'hF, 32'h0, 8'h62);

        w = 0;
        while (sb.size() != 0 && w < 200) begin
            w++;
            @(posedge clk);
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL drain got=%0d_pending want=0", sb.size());
        end
        idle(2);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/mem_responder_l7.md
# mem_responder_l7

Memory-side responder for the `MemIntf` protocol: accepts read/write requests from a client execute unit or fetch unit, services them against a word-addressed backing store with byte-strobe writes, and returns in-order responses after a fixed, parameterised latency. It is the server end of the same interface that the load/store units drive. It is used as a synthesizable scratchpad and as the memory model in execute-unit and processor-level benches.

## Interface
- `p_opaq_bits`, 8, width of the opaque field carried request→response.
- `p_num_words`, 256, backing store size in 32-bit words; power of 2, ≥ 2.
- `p_latency`, 1, cycles from request acceptance to earliest response; ≥ 1.
- `p_queue_depth`, 4, maximum outstanding requests, counting accepted but not yet dequeued; ≥ 1.
- `clk`  input  1  clock; all state updates on posedge.
- `rst`  input  1  reset; synchronous, active-high.
- `mem`  modport `MemIntf.server`  —  carries the signals below.
  - `req_val`/`req_rdy`  in/out  1/1.
  - `req_msg`  in  {op `t_op`, opaque, addr 32, strb 4, data 32}.
  - `resp_val`/`resp_rdy`  out/in  1/1.
  - `resp_msg`  out  same layout as `req_msg`.

## Operation
- Request accepted when `req_val & req_rdy`. `req_rdy = (count < p_queue_depth)`, where `count` is the registered queue occupancy. There is no same-cycle bypass: a full queue stays not-ready even while the head is dequeuing.
- Word index is `addr[$clog2(p_num_words)+1:2]`.
  - `addr[1:0]` is ignored; requests are word-aligned by the client.
  - Upper address bits are ignored, so addresses alias modulo `4*p_num_words`.
- WRITE (`MEM_MSG_WRITE`):
  - On the acceptance edge, byte i of the word is replaced by `data[8i+7:8i]` for each `strb[i]=1`; other bytes are unchanged.
  - `strb=0000` is legal and leaves the word unchanged.
- READ (`MEM_MSG_READ`):
  - The full 32-bit word is sampled at acceptance, before any write accepted in the same cycle (none is possible: one request per cycle).
  - `strb` does not mask read data.
  - A read accepted in the cycle after a write to the same word returns the written value.
- On acceptance, an entry is enqueued at the tail: {op, opaque, addr, strb, rdata, countdown = p_latency-1}.
  - `rdata` is the read word, or 32'h0 for writes.
- Every cycle, each valid entry's nonzero countdown decrements by 1.
- `resp_val = head valid & head countdown == 0`.
- `resp_msg` = head {op, opaque, addr, strb, rdata}; every field is echoed unchanged from the request except data.
- Dequeue on `resp_val & resp_rdy`.
- Responses are strictly in acceptance order.
- Occupancy update: `count` increments on accept-only, decrements on dequeue-only, and is unchanged when both happen in one cycle.
- Queue storage is a circular buffer with head/tail pointers; pointers wrap at `p_queue_depth`, which need not be a power of 2.
- Backing store is not reset; contents are X until written.
- Line trace: under non-`SYNTHESIS`, `trace(trace_level)` prints accepted requests and sent responses in the same `op:opaque:addr:data` style as the execute units.

## Timing
- Reset values: `req_rdy=1`, `resp_val=0`, `count=0`, head=tail=0. `resp_msg` is don't-care while `resp_val=0`.
- Reset taken mid-operation:
  - All queued and in-flight entries are discarded; no response is emitted for them.
  - Writes already accepted remain in the store.
  - `resp_val=0` and `req_rdy=1` hold in the cycle after `rst` is sampled.
- Latency: a request accepted at edge T drives `resp_val` high in cycle T+`p_latency`, provided all older entries have been dequeued.
- `resp_msg` holds stable while `resp_val=1 & resp_rdy=0`.
- Throughput: one request per cycle sustained with `resp_rdy=1`, if and only if `p_queue_depth ≥ p_latency+1`. Otherwise acceptance stalls to `p_queue_depth` per `p_latency+1` cycles.
- `req_rdy` and `resp_val` depend only on registered state; there is no combinational path from `req_val` or `resp_rdy`.

## Test plan
- Basic write/read (L=1, depth=4):
  - WRITE addr 0x10, data 0xDEADBEEF, strb 1111, opaque 0x03 → next cycle resp {WRITE, 0x03, 0x10, 1111, 0x00000000}.
  - Then READ 0x10, opaque 0x04 → next cycle data 0xDEADBEEF, opaque 0x04.
- Strobed write, then read the next cycle: WRITE 0x10, data 0x0000AB00, strb 0010, then READ 0x10 back-to-back → read data 0xDEADABEF; also `strb=0000` leaves 0xDEADABEF.
- Pipelined stream (L=3, depth=4, `resp_rdy=1`): 8 reads to 0x00..0x1C issued every cycle after writes of i+1 → `req_rdy` never drops; responses 1..8 on 8 consecutive cycles, the first 3 cycles after the first acceptance, in order.
- Backpressure (L=1, depth=4, `resp_rdy=0`):
  - 4 requests accepted; `req_rdy=0` from the cycle after the 4th; `resp_msg` stable.
  - Raise `resp_rdy` for 1 cycle → one dequeue, `req_rdy=1` the following cycle.
- Aliasing (`p_num_words=256`): WRITE 0x400 data 0x12345678 → READ 0x000 returns 0x12345678.
- Reset mid-operation (L=3): 2 requests outstanding, assert `rst` for 1 cycle → `resp_val=0`, `req_rdy=1`, and no stale responses in the following 5 cycles. A subsequent read of a previously written address returns the written data.
